// File: rtl/ece423_i2c_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : ece423_i2c_pkg                                        |
// | Purpose  : Shared types and constants for the I2C target:        |
// |            FSM state encoding, Avalon register offsets and       |
// |            STATUS bit positions.                                 |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
package ece423_i2c_pkg;

    // Target FSM states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_ACK_A  = 3'd2,
        ST_RX     = 3'd3,
        ST_ACK_R  = 3'd4,
        ST_TX     = 3'd5,
        ST_WAIT_M = 3'd6
    } i2c_state_e;

    // Avalon word offsets
    localparam logic [1:0] c_reg_rxdata = 2'd0;
    localparam logic [1:0] c_reg_txdata = 2'd1;
    localparam logic [1:0] c_reg_status = 2'd2;
    localparam logic [1:0] c_reg_rsvd   = 2'd3;

    // STATUS bit positions
    localparam int c_stat_rx_valid  = 0;
    localparam int c_stat_tx_full   = 1;
    localparam int c_stat_overrun   = 2;
    localparam int c_stat_underrun  = 3;
    localparam int c_stat_busy      = 4;
    localparam int c_stat_addressed = 5;

    // True once our address has been matched and until the transfer ends
    function automatic logic is_addressed(input i2c_state_e s);
        return (s == ST_ACK_A) || (s == ST_RX) || (s == ST_ACK_R) ||
               (s == ST_TX) || (s == ST_WAIT_M);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ece423_i2c_target_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : ece423_i2c_target_if                                  |
// | Purpose  : Avalon-MM register slave bus of the I2C target.       |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
interface ece423_i2c_target_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface
`default_nettype wire

// File: rtl/ece423_i2c_bus_sync.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : ece423_i2c_bus_sync                                   |
// | Purpose  : Synchronizes SCL/SDA into clk, detects SCL edges and  |
// |            START/STOP conditions.                                |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module ece423_i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic scl,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_d;
    logic                   r_sda_d;
    logic                   w_scl_s;
    logic                   w_sda_s;

    // Synchronizer chain plus one history flop; resets to the idle-high bus level
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
            r_scl_d    <= w_scl_s;
            r_sda_d    <= w_sda_s;
        end
    end

    assign w_scl_s   = r_scl_sync[SYNC_STAGES-1];
    assign w_sda_s   = r_sda_sync[SYNC_STAGES-1];
    assign sda_s     = w_sda_s;
    assign scl_rise  = w_scl_s & ~r_scl_d;
    assign scl_fall  = ~w_scl_s & r_scl_d;
    // SDA moving while SCL is high is a bus condition, not data
    assign start_det = w_scl_s & r_scl_d & r_sda_d & ~w_sda_s;
    assign stop_det  = w_scl_s & r_scl_d & ~r_sda_d & w_sda_s;

endmodule
`default_nettype wire

// File: rtl/ece423_i2c_target.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : ece423_i2c_target                                     |
// | Purpose  : I2C target with a fixed 7-bit address and an Avalon-MM|
// |            register slave (RXDATA, TXDATA, STATUS).              |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module ece423_i2c_target
    import ece423_i2c_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR    = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    ece423_i2c_target_if.slave         bus,
    input  logic                       scl,
    inout  wire                        sda
);

    // Bus-side events
    logic w_scl_rise, w_scl_fall, w_start, w_stop, w_sda_s;

    // FSM and datapath
    i2c_state_e r_state;
    logic [7:0] r_shift;
    logic [3:0] r_bit_cnt;
    logic       r_rw;
    logic       r_mack;
    logic       r_sda_oe;

    // Register file
    logic [7:0]  r_rx_data;
    logic        r_rx_valid;
    logic [7:0]  r_tx_data;
    logic        r_tx_full;
    logic        r_overrun;
    logic        r_underrun;
    logic [31:0] r_readdata;

    // Avalon decode
    logic        w_rd, w_wr, w_rx_read, w_tx_write, w_stat_write;
    logic [31:0] w_status;
    logic        w_tx_load;
    logic [7:0]  w_tx_byte;
    logic        w_unused;

    ece423_i2c_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_bus_sync (
        .clk       (clk),
        .reset_n   (reset_n),
        .scl       (scl),
        .sda_in    (sda),
        .scl_rise  (w_scl_rise),
        .scl_fall  (w_scl_fall),
        .start_det (w_start),
        .stop_det  (w_stop),
        .sda_s     (w_sda_s)
    );

    assign sda = r_sda_oe ? 1'b0 : 1'bz;

    assign w_rd         = bus.chipselect & bus.write_n;
    assign w_wr         = bus.chipselect & ~bus.write_n;
    assign w_rx_read    = w_rd && (bus.address == c_reg_rxdata);
    assign w_tx_write   = w_wr && (bus.address == c_reg_txdata);
    assign w_stat_write = w_wr && (bus.address == c_reg_status);
    assign w_unused     = ^bus.writedata[31:8];

    always_comb begin
        w_status                    = 32'd0;
        w_status[c_stat_rx_valid]   = r_rx_valid;
        w_status[c_stat_tx_full]    = r_tx_full;
        w_status[c_stat_overrun]    = r_overrun;
        w_status[c_stat_underrun]   = r_underrun;
        w_status[c_stat_busy]       = (r_state != ST_IDLE);
        w_status[c_stat_addressed]  = is_addressed(r_state);
    end

    // An empty TXDATA still has to put something on the bus: send all-ones
    assign w_tx_byte = r_tx_full ? r_tx_data : 8'hFF;

    // A new transmit byte is loaded on the SCL fall that ends an ACK slot
    assign w_tx_load = w_scl_fall && !w_start && !w_stop &&
                       (((r_state == ST_ACK_A) && r_rw) ||
                        ((r_state == ST_WAIT_M) && (r_bit_cnt == 4'd1) && !r_mack));

    // Protocol FSM, shifter and register side effects; later assignments win
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_shift    <= 8'd0;
            r_bit_cnt  <= 4'd0;
            r_rw       <= 1'b0;
            r_mack     <= 1'b1;
            r_sda_oe   <= 1'b0;
            r_rx_data  <= 8'd0;
            r_rx_valid <= 1'b0;
            r_tx_data  <= 8'd0;
            r_tx_full  <= 1'b0;
            r_overrun  <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            if (w_tx_write) begin
                r_tx_data <= bus.writedata[7:0];
                r_tx_full <= 1'b1;
            end
            if (w_rx_read) begin
                r_rx_valid <= 1'b0;
            end
            if (w_stat_write) begin
                if (bus.writedata[c_stat_overrun])  r_overrun  <= 1'b0;
                if (bus.writedata[c_stat_underrun]) r_underrun <= 1'b0;
            end

            if (w_start) begin
                r_state   <= ST_ADDR;
                r_bit_cnt <= 4'd0;
                r_shift   <= 8'd0;
                r_sda_oe  <= 1'b0;
            end else if (w_stop) begin
                r_state   <= ST_IDLE;
                r_sda_oe  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_sda_oe <= 1'b0;
                    end
                    ST_ADDR: begin
                        if (w_scl_rise) begin
                            r_shift   <= {r_shift[6:0], w_sda_s};
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (w_scl_fall && (r_bit_cnt == 4'd8)) begin
                            r_bit_cnt <= 4'd0;
                            if (r_shift[7:1] == I2C_ADDR) begin
                                r_state  <= ST_ACK_A;
                                r_rw     <= r_shift[0];
                                r_sda_oe <= 1'b1;
                            end else begin
                                r_state  <= ST_IDLE;
                            end
                        end
                    end
                    ST_ACK_A: begin
                        if (w_scl_fall) begin
                            r_bit_cnt <= 4'd0;
                            r_sda_oe  <= 1'b0;
                            r_state   <= r_rw ? ST_TX : ST_RX;
                        end
                    end
                    ST_RX: begin
                        if (w_scl_rise) begin
                            r_shift   <= {r_shift[6:0], w_sda_s};
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (w_scl_fall && (r_bit_cnt == 4'd8)) begin
                            r_bit_cnt <= 4'd0;
                            // A read on this same edge frees the holding register
                            if (!r_rx_valid || w_rx_read) begin
                                r_rx_data  <= r_shift;
                                r_rx_valid <= 1'b1;
                                r_sda_oe   <= 1'b1;
                                r_state    <= ST_ACK_R;
                            end else begin
                                r_overrun  <= 1'b1;
                                r_sda_oe   <= 1'b0;
                                r_state    <= ST_IDLE;
                            end
                        end
                    end
                    ST_ACK_R: begin
                        if (w_scl_fall) begin
                            r_sda_oe  <= 1'b0;
                            r_bit_cnt <= 4'd0;
                            r_state   <= ST_RX;
                        end
                    end
                    ST_TX: begin
                        if (w_scl_rise) begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (w_scl_fall) begin
                            if (r_bit_cnt == 4'd8) begin
                                r_sda_oe  <= 1'b0;
                                r_bit_cnt <= 4'd0;
                                r_state   <= ST_WAIT_M;
                            end else begin
                                r_shift  <= {r_shift[6:0], 1'b0};
                                r_sda_oe <= ~r_shift[6];
                            end
                        end
                    end
                    ST_WAIT_M: begin
                        if (w_scl_rise) begin
                            r_mack    <= w_sda_s;
                            r_bit_cnt <= 4'd1;
                        end else if (w_scl_fall && (r_bit_cnt == 4'd1)) begin
                            r_bit_cnt <= 4'd0;
                            r_state   <= r_mack ? ST_IDLE : ST_TX;
                        end
                    end
                    default: begin
                        r_state  <= ST_IDLE;
                        r_sda_oe <= 1'b0;
                    end
                endcase

                // First bit goes out on the same fall that loads the byte
                if (w_tx_load) begin
                    r_shift   <= w_tx_byte;
                    r_sda_oe  <= ~w_tx_byte[7];
                    r_bit_cnt <= 4'd0;
                    if (!r_tx_full) r_underrun <= 1'b1;
                    if (!w_tx_write) r_tx_full <= 1'b0;
                end
            end
        end
    end

    // Registered read mux, one-cycle latency
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_readdata <= 32'd0;
        end else begin
            case (bus.address)
                c_reg_rxdata: r_readdata <= {24'd0, r_rx_data};
                c_reg_txdata: r_readdata <= {24'd0, r_tx_data};
                c_reg_status: r_readdata <= w_status;
                default:      r_readdata <= 32'd0;
            endcase
        end
    end

    assign bus.readdata = r_readdata;

endmodule
`default_nettype wire
